// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and defaults for push-button conditioning front ends.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package button_pulse_conditioner_pkg;

   // Auto-repeat channel states, shared with other button-driven setters
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      LOCK   = 2'd3
   } rep_state_t;

   // Defaults sized for a fast board clock
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_HOLD_CYCLES     = 25000000;
   localparam int DEF_REPEAT_CYCLES   = 5000000;

   // Counter width able to hold 0..n without wrapping
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/button_pulse_conditioner_debouncer.sv
// Synchronises one raw button, debounces it to a stable level, strobes on rise.
// Latency: level flips DEBOUNCE_CYCLES+2 edges after a stable raw change; rise strobe on that same edge.
// Backpressure: none; free-running per clock.
import button_pulse_conditioner_pkg::*;

module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing cycles; flip level once the run is long enough
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         if (r_sync2 != r_level) begin
            if (r_cnt == LAST) begin
               r_level <= r_sync2;
               r_rise  <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Turns raw set/up/down buttons into single-cycle pulses; up/down auto-repeat while held.
// Latency: press pulse DEBOUNCE_CYCLES+3 edges after raw rises; repeats at +HOLD_CYCLES, then every REPEAT_CYCLES.
// Backpressure: none; set pulse pre-empts a coincident up/down pulse, which is dropped.
import button_pulse_conditioner_pkg::*;

module button_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_set_raw,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic pulsed_set,
   output logic pulsed_up,
   output logic pulsed_down
);

   localparam int               MAXC      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int               RCW       = cnt_width(MAXC);
   localparam logic [RCW-1:0]   HOLD_LAST = RCW'(HOLD_CYCLES - 1);
   localparam logic [RCW-1:0]   REP_LAST  = RCW'(REPEAT_CYCLES - 1);

   logic           w_set_level;
   logic           w_set_rise;
   logic [1:0]     w_level;      // [0]=up, [1]=down
   logic [1:0]     w_rise;
   logic           w_both_held;
   logic [1:0]     w_pulse_req;

   rep_state_t     r_state     [2];
   rep_state_t     w_state_nxt [2];
   logic [RCW-1:0] r_cnt       [2];
   logic [RCW-1:0] w_cnt_nxt   [2];

   logic           r_pulsed_set;
   logic           r_pulsed_up;
   logic           r_pulsed_down;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .i_clk(clk), .i_rst_n(reset), .i_raw(btn_set_raw),
      .o_level(w_set_level), .o_rise(w_set_rise)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
      .i_clk(clk), .i_rst_n(reset), .i_raw(btn_up_raw),
      .o_level(w_level[0]), .o_rise(w_rise[0])
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
      .i_clk(clk), .i_rst_n(reset), .i_raw(btn_down_raw),
      .o_level(w_level[1]), .o_rise(w_rise[1])
   );

   // Up and down together is ambiguous, so both channels lock out
   assign w_both_held = w_level[0] & w_level[1];

   // Repeat FSM state register: state and hold/repeat counter per channel
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            r_state[ch] <= IDLE;
            r_cnt[ch]   <= '0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            r_state[ch] <= w_state_nxt[ch];
            r_cnt[ch]   <= w_cnt_nxt[ch];
         end
      end
   end

   // Repeat FSM next state; counter rests at zero outside HOLD/REPEAT
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         w_state_nxt[ch] = r_state[ch];
         w_cnt_nxt[ch]   = '0;
         if (w_both_held) begin
            w_state_nxt[ch] = LOCK;
         end else begin
            case (r_state[ch])
               IDLE: begin
                  if (w_rise[ch]) w_state_nxt[ch] = HOLD;
               end
               HOLD: begin
                  if (!w_level[ch])              w_state_nxt[ch] = IDLE;
                  else if (r_cnt[ch] == HOLD_LAST) w_state_nxt[ch] = REPEAT;
                  else                             w_cnt_nxt[ch]   = r_cnt[ch] + 1'b1;
               end
               REPEAT: begin
                  if (!w_level[ch])               w_state_nxt[ch] = IDLE;
                  else if (r_cnt[ch] != REP_LAST) w_cnt_nxt[ch]   = r_cnt[ch] + 1'b1;
               end
               LOCK: begin
                  if (!w_level[ch]) w_state_nxt[ch] = IDLE;
               end
               default: w_state_nxt[ch] = IDLE;
            endcase
         end
      end
   end

   // Repeat FSM outputs: press pulse, first repeat at end of hold, then periodic
   always_comb begin
      w_pulse_req = '0;
      for (int ch = 0; ch < 2; ch++) begin
         if (!w_both_held) begin
            case (r_state[ch])
               IDLE:    w_pulse_req[ch] = w_rise[ch];
               HOLD:    w_pulse_req[ch] = w_level[ch] && (r_cnt[ch] == HOLD_LAST);
               REPEAT:  w_pulse_req[ch] = w_level[ch] && (r_cnt[ch] == REP_LAST);
               default: w_pulse_req[ch] = 1'b0;
            endcase
         end
      end
   end

   // Registered pulses; a set pulse masks up/down for that cycle only
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pulsed_set  <= 1'b0;
         r_pulsed_up   <= 1'b0;
         r_pulsed_down <= 1'b0;
      end else begin
         r_pulsed_set  <= w_set_rise & w_set_level;
         r_pulsed_up   <= w_pulse_req[0] & ~(w_set_rise & w_set_level);
         r_pulsed_down <= w_pulse_req[1] & ~(w_set_rise & w_set_level);
      end
   end

   assign pulsed_set  = r_pulsed_set;
   assign pulsed_up   = r_pulsed_up;
   assign pulsed_down = r_pulsed_down;

endmodule
